oled_fb_fetch: RTL and testbench
================================

# oled_fb_fetch

Pixel-fetch stage between the 80x60 camera frame buffer (read port) and the `oled_video` SPI driver. It turns the driver's `x`/`y` scan position into a frame-buffer address and reads the stored RGB565 word. It places the 80x60 image top-left in the 96x64 OLED raster with a border colour elsewhere, and returns `color`. A small state machine holds off camera writes while one OLED frame is being served, so each OLED frame shows a single camera frame with no tearing.

## Interface
- `IMG_COLS`, 80, stored image width
- `IMG_ROWS`, 60, stored image height
- `NB_ADDR`, 13, frame-buffer address width
- `OLED_COLS`, 96, OLED raster width
- `OLED_ROWS`, 64, OLED raster height
- `BORDER`, 16'hF800, RGB565 colour outside the image window
- `clk` in 1 — single clock (`oclk`, 50 MHz)
- `rst` in 1 — reset; synchronous, active-high
- `next_pixel` in 1 — pulse from `oled_video`: pixel at current `x`,`y` consumed; `x`,`y` advance
- `x` in 7 — OLED column, 0..95
- `y` in 7 — OLED row, 0..63
- `swap_r_b` in 1 — swap the 5-bit R and B fields of the output
- `freeze` in 1 — hold camera writes indefinitely (freeze displayed image)
- `cap_frame_done` in 1 — one-cycle pulse when the capture block wraps to address 0
- `fb_addr` out `NB_ADDR` — frame-buffer read address (registered)
- `fb_pxl` in 16 — frame-buffer read data, valid 1 cycle after `fb_addr`
- `color` out 16 — RGB565 to `oled_video`
- `cap_hold` out 1 — high: the capture write enable must be gated off
- `frame_cnt` out 8 — number of completed OLED frames served

## Operation
- Window: `in_win = (x < IMG_COLS) && (y < IMG_ROWS)`.
- Address: `y*IMG_COLS + x`, built as `(y<<6)+(y<<4)+x` for the default width of 80. The result is truncated to `NB_ADDR` bits. When `in_win=0`, `fb_addr` holds its previous value.
- Output: `in_win=1` gives `fb_pxl`. `in_win=0` gives `BORDER`. `swap_r_b=1` exchanges bits [15:11] and [4:0]; G [10:5] is unchanged. `BORDER` is also swapped.
- The fetch pipeline runs every cycle, independent of state.
- FSM states:
  - IDLE → WAIT on the first cycle after reset.
  - WAIT: on `cap_frame_done` → ARM.
  - ARM: on `next_pixel` with `x=0, y=0` → SCAN.
  - SCAN: on `next_pixel` with `x=OLED_COLS-1, y=OLED_ROWS-1` → WAIT, and `frame_cnt` increments (wraps 255→0).
- `cap_hold = (state==ARM || state==SCAN || freeze)`.
- Boundary cases:
  - `cap_frame_done` in ARM or SCAN is ignored.
  - `cap_frame_done` and a last-pixel `next_pixel` in the same cycle: SCAN→WAIT only; the pulse is lost.
  - `freeze` does not alter state transitions.
  - `x`/`y` out of range (≥96 / ≥64) are treated as out-of-window.
  - `rst` mid-SCAN: state goes to IDLE, `cap_hold` drops on the next edge.

## Timing
- Reset values: `fb_addr=0`, `color=BORDER` (unswapped), `cap_hold=0`, `frame_cnt=0`, state IDLE, pipeline flags 0.
- Stage 0: register `in_win`; register `fb_addr`.
- Stage 1: frame-buffer BRAM read (external).
- Stage 2: register `color`.
- Latency is 3 clocks from `x`/`y` change to `color` valid. `oled_video` spends ≥32 clocks per pixel, so no stall is needed.
- `cap_hold` is registered: it asserts 1 clock after the ARM entry edge.

## Configuration
- `OLED_FETCH_TESTPAT_EN` defined:
  - Adds input `testpat` (1 bit).
  - When high, `color` is 8 vertical colour bars, 12 columns each, bar index `x/12`. Bar colours in order: white, yellow, cyan, green, magenta, red, blue, black.
  - Bars are shown over the whole 96x64 raster and bypass the frame buffer.
  - The FSM still runs.
- Undefined: no `testpat` port; the output is always the frame or the border.

## Structure
- Package `oled_fetch_pkg` holds:
  - FSM state encoding (IDLE, WAIT, ARM, SCAN)
  - RGB565 field positions
  - the eight bar colours
  - the default `BORDER`
- Sub-module `oled_fb_addr_gen`: registered `x`,`y` → `fb_addr` + `in_win` (stage 0).

## Test plan
- Reset → `color=16'hF800`, `cap_hold=0`, `frame_cnt=0`. After one clock the FSM is in WAIT.
- Fill the buffer with `mem[a]=a`; `x=79, y=59` → `fb_addr=4799`, and `color=4799` 3 clocks later.
- `x=80, y=10` → `color=BORDER`. With `swap_r_b=1`, `BORDER=16'hF800` → `color=16'h001F`.
- `cap_frame_done` pulse, then `next_pixel` at (0,0) → `cap_hold=1`. A full 6144-pixel scan → `cap_hold=0`, `frame_cnt=1`.
- Assert `rst` mid-SCAN → `cap_hold=0` next clock. A `cap_frame_done` arriving during SCAN is ignored: 2 pulses in SCAN give no re-arm until the next pulse in WAIT.
- With `OLED_FETCH_TESTPAT_EN` and `testpat=1`: `x=0` → `16'hFFFF`; `x=60` → `16'hF800`; `x=95` → `16'h0000`.

Source files
------------

// File: rtl/oled_fetch_pkg.sv
// ============================================================================
//  Module      : oled_fetch_pkg
//  Description : Shared types and constants for the OLED frame-buffer fetch
//                stage: FSM encoding, RGB565 fields, colour bars, border.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package oled_fetch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ARM  = 2'd2,
      ST_SCAN = 2'd3
   } fetch_state_t;

   localparam int R_MSB = 15;
   localparam int R_LSB = 11;
   localparam int G_MSB = 10;
   localparam int G_LSB = 5;
   localparam int B_MSB = 4;
   localparam int B_LSB = 0;

   localparam logic [15:0] BORDER_DEFAULT = 16'hF800;
   localparam int          BAR_WIDTH      = 12;

   localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
   localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
   localparam logic [15:0] BAR_CYAN    = 16'h07FF;
   localparam logic [15:0] BAR_GREEN   = 16'h07E0;
   localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
   localparam logic [15:0] BAR_RED     = 16'hF800;
   localparam logic [15:0] BAR_BLUE    = 16'h001F;
   localparam logic [15:0] BAR_BLACK   = 16'h0000;

   function automatic logic [15:0] bar_color(input logic [2:0] idx);
      logic [15:0] c;
      case (idx)
         3'd0:    c = BAR_WHITE;
         3'd1:    c = BAR_YELLOW;
         3'd2:    c = BAR_CYAN;
         3'd3:    c = BAR_GREEN;
         3'd4:    c = BAR_MAGENTA;
         3'd5:    c = BAR_RED;
         3'd6:    c = BAR_BLUE;
         default: c = BAR_BLACK;
      endcase
      return c;
   endfunction

   // Exchange the 5-bit red and blue fields; green stays in place.
   function automatic logic [15:0] swap_rb(input logic [15:0] c);
      return {c[B_MSB:B_LSB], c[G_MSB:G_LSB], c[R_MSB:R_LSB]};
   endfunction

endpackage

`default_nettype wire

// File: rtl/oled_fb_addr_gen.sv
// ============================================================================
//  Module      : oled_fb_addr_gen
//  Description : Stage 0 of the fetch pipeline: OLED x/y to registered
//                frame-buffer address and image-window flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module oled_fb_addr_gen
   import oled_fetch_pkg::*;
#(
   parameter int IMG_COLS = 80,
   parameter int IMG_ROWS = 60,
   parameter int NB_ADDR  = 13
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [6:0]         x,
   input  logic [6:0]         y,
   output logic [NB_ADDR-1:0] fb_addr,
   output logic               in_win
);

   logic [NB_ADDR-1:0] y_ext;
   logic [NB_ADDR-1:0] x_ext;
   logic [NB_ADDR-1:0] addr_calc;
   logic [NB_ADDR-1:0] fb_addr_d, fb_addr_q;
   logic               in_win_d, in_win_q;

   assign y_ext = NB_ADDR'(y);
   assign x_ext = NB_ADDR'(x);

   generate
      if (IMG_COLS == 80) begin : g_addr_shift
         // 80 = 64 + 16, so the row offset needs only two shifts and an add.
         assign addr_calc = (y_ext << 6) + (y_ext << 4) + x_ext;
      end else begin : g_addr_mul
         assign addr_calc = y_ext * NB_ADDR'(IMG_COLS) + x_ext;
      end
   endgenerate

   always_comb begin
      in_win_d  = (x < 7'(IMG_COLS)) && (y < 7'(IMG_ROWS));
      fb_addr_d = in_win_d ? addr_calc : fb_addr_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fb_addr_q <= '0;
         in_win_q  <= 1'b0;
      end else begin
         fb_addr_q <= fb_addr_d;
         in_win_q  <= in_win_d;
      end
   end

   assign fb_addr = fb_addr_q;
   assign in_win  = in_win_q;

endmodule

`default_nettype wire

// File: rtl/oled_fb_fetch.sv
// ============================================================================
//  Module      : oled_fb_fetch
//  Description : Pixel fetch between the camera frame buffer and the OLED
//                driver, with tear-free capture hold-off FSM.
//                Optional colour-bar test pattern: OLED_FETCH_TESTPAT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module oled_fb_fetch
   import oled_fetch_pkg::*;
#(
   parameter int          IMG_COLS  = 80,
   parameter int          IMG_ROWS  = 60,
   parameter int          NB_ADDR   = 13,
   parameter int          OLED_COLS = 96,
   parameter int          OLED_ROWS = 64,
   parameter logic [15:0] BORDER    = BORDER_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               next_pixel,
   input  logic [6:0]         x,
   input  logic [6:0]         y,
   input  logic               swap_r_b,
   input  logic               freeze,
   input  logic               cap_frame_done,
`ifdef OLED_FETCH_TESTPAT_EN
   input  logic               testpat,
`endif
   output logic [NB_ADDR-1:0] fb_addr,
   input  logic [15:0]        fb_pxl,
   output logic [15:0]        color,
   output logic               cap_hold,
   output logic [7:0]         frame_cnt
);

   logic         in_win_s0;
   logic         in_win_s1_d, in_win_s1_q;
   logic [15:0]  pix;
   logic [15:0]  color_d, color_q;

   fetch_state_t state_d, state_q;
   logic         cap_hold_d, cap_hold_q;
   logic [7:0]   frame_cnt_d, frame_cnt_q;
   logic         is_first_px;
   logic         is_last_px;

   oled_fb_addr_gen #(
      .IMG_COLS (IMG_COLS),
      .IMG_ROWS (IMG_ROWS),
      .NB_ADDR  (NB_ADDR)
   ) u_addr_gen (
      .clk     (clk),
      .rst     (rst),
      .x       (x),
      .y       (y),
      .fb_addr (fb_addr),
      .in_win  (in_win_s0)
   );

`ifdef OLED_FETCH_TESTPAT_EN
   logic [2:0] bar_s0_d, bar_s0_q;
   logic [2:0] bar_s1_d, bar_s1_q;

   always_comb begin
      bar_s0_d = ((x < 7'(OLED_COLS)) && (y < 7'(OLED_ROWS))) ?
                 3'(x / 7'(BAR_WIDTH)) : 3'd7;
      bar_s1_d = bar_s0_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bar_s0_q <= 3'd0;
         bar_s1_q <= 3'd0;
      end else begin
         bar_s0_q <= bar_s0_d;
         bar_s1_q <= bar_s1_d;
      end
   end
`endif

   // Window flag is delayed one more stage to line up with the BRAM read data.
   always_comb begin
      in_win_s1_d = in_win_s0;
      pix         = in_win_s1_q ? fb_pxl : BORDER;
`ifdef OLED_FETCH_TESTPAT_EN
      if (testpat) begin
         pix = bar_color(bar_s1_q);
      end
`endif
      color_d = swap_r_b ? swap_rb(pix) : pix;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         in_win_s1_q <= 1'b0;
         color_q     <= BORDER;
      end else begin
         in_win_s1_q <= in_win_s1_d;
         color_q     <= color_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      frame_cnt_d = frame_cnt_q;
      is_first_px = next_pixel && (x == 7'd0) && (y == 7'd0);
      is_last_px  = next_pixel && (x == 7'(OLED_COLS - 1)) &&
                    (y == 7'(OLED_ROWS - 1));
      case (state_q)
         ST_IDLE: state_d = ST_WAIT;
         ST_WAIT: if (cap_frame_done) state_d = ST_ARM;
         ST_ARM:  if (is_first_px) state_d = ST_SCAN;
         ST_SCAN: begin
            if (is_last_px) begin
               state_d     = ST_WAIT;
               frame_cnt_d = frame_cnt_q + 8'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Follows the current state, so the hold lags ARM entry by one clock.
      cap_hold_d = (state_q == ST_ARM) || (state_q == ST_SCAN) || freeze;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cap_hold_q  <= 1'b0;
         frame_cnt_q <= 8'd0;
      end else begin
         state_q     <= state_d;
         cap_hold_q  <= cap_hold_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign color     = color_q;
   assign cap_hold  = cap_hold_q;
   assign frame_cnt = frame_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_oled_fb_fetch.sv
// ============================================================================
//  Module      : tb_oled_fb_fetch
//  Description : Self-checking bench for oled_fb_fetch with a behavioural
//                frame-buffer and pixel reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_oled_fb_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        next_pixel = 1'b0;
   logic [6:0]  x = 7'd0;
   logic [6:0]  y = 7'd0;
   logic        swap_r_b = 1'b0;
   logic        freeze = 1'b0;
   logic        cap_frame_done = 1'b0;
`ifdef OLED_FETCH_TESTPAT_EN
   logic        testpat = 1'b0;
`endif
   logic [12:0] fb_addr;
   logic [15:0] fb_pxl = 16'h0000;
   logic [15:0] color;
   logic        cap_hold;
   logic [7:0]  frame_cnt;

   logic [15:0] mem [0:8191];

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   // Synchronous-read frame buffer: data one clock after the address.
   always @(posedge clk) fb_pxl <= mem[fb_addr];

   oled_fb_fetch dut (
      .clk            (clk),
      .rst            (rst),
      .next_pixel     (next_pixel),
      .x              (x),
      .y              (y),
      .swap_r_b       (swap_r_b),
      .freeze         (freeze),
      .cap_frame_done (cap_frame_done),
`ifdef OLED_FETCH_TESTPAT_EN
      .testpat        (testpat),
`endif
      .fb_addr        (fb_addr),
      .fb_pxl         (fb_pxl),
      .color          (color),
      .cap_hold       (cap_hold),
      .frame_cnt      (frame_cnt)
   );

   function automatic logic [15:0] ref_swap(input logic [15:0] c, input bit s);
      return s ? {c[4:0], c[10:5], c[15:11]} : c;
   endfunction

   function automatic logic [15:0] ref_pixel(input int px, input int py, input bit s);
      logic [15:0] c;
      if (px < 80 && py < 60) c = mem[py * 80 + px];
      else                    c = 16'hF800;
      return ref_swap(c, s);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pixel(input int px, input int py, input bit cfd);
      x = 7'(px); y = 7'(py);
      next_pixel = 1'b1; cap_frame_done = cfd;
      tick();
      next_pixel = 1'b0; cap_frame_done = 1'b0;
   endtask

   task automatic scan_frame(input int p1, input int p2);
      for (int py = 0; py < 64; py++)
         for (int px = 0; px < 96; px++)
            pixel(px, py, (py * 96 + px == p1) || (py * 96 + px == p2));
   endtask

   task automatic pulse_cfd();
      cap_frame_done = 1'b1;
      tick();
      cap_frame_done = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tests_run++;
      if (color !== 16'hF800) begin
         tests_failed++; $display("FAIL reset_color got %h want %h", color, 16'hF800);
      end
      tests_run++;
      if (cap_hold !== 1'b0 || frame_cnt !== 8'd0 || fb_addr !== 13'd0) begin
         tests_failed++;
         $display("FAIL reset_ctrl got hold=%b cnt=%0d addr=%0d want 0/0/0", cap_hold, frame_cnt, fb_addr);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_corner();
      for (int a = 0; a < 8192; a++) mem[a] = 16'(a);
      swap_r_b = 1'b0; x = 7'd79; y = 7'd59;
      tick();
      tests_run++;
      if (fb_addr !== 13'd4799) begin
         tests_failed++; $display("FAIL corner_addr got %0d want 4799", fb_addr);
      end
      tick(); tick();
      tests_run++;
      if (color !== 16'd4799) begin
         tests_failed++; $display("FAIL corner_color got %0d want 4799", color);
      end
   endtask

   task automatic test_border();
      x = 7'd80; y = 7'd10; swap_r_b = 1'b0;
      tick(); tick(); tick();
      tests_run++;
      if (color !== 16'hF800 || fb_addr !== 13'd4799) begin
         tests_failed++; $display("FAIL border got color=%h addr=%0d want F800/4799", color, fb_addr);
      end
      swap_r_b = 1'b1;
      tick(); tick(); tick();
      tests_run++;
      if (color !== 16'h001F) begin
         tests_failed++; $display("FAIL border_swap got %h want 001F", color);
      end
      x = 7'd120; y = 7'd127; swap_r_b = 1'b0;
      tick(); tick(); tick();
      tests_run++;
      if (color !== 16'hF800 || fb_addr !== 13'd4799) begin
         tests_failed++; $display("FAIL out_of_range got color=%h addr=%0d want F800/4799", color, fb_addr);
      end
   endtask

   task automatic test_random();
      for (int a = 0; a < 8192; a++) mem[a] = 16'($urandom);
      for (int i = 0; i < 40; i++) begin
         int px, py;
         bit s;
         px = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 79) : $urandom_range(0, 127);
         py = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 59) : $urandom_range(0, 127);
         s  = 1'($urandom_range(0, 1));
         x = 7'(px); y = 7'(py); swap_r_b = s;
         tick();
         if (px < 80 && py < 60) begin
            tests_run++;
            if (fb_addr !== 13'(py * 80 + px)) begin
               tests_failed++; $display("FAIL rand_addr (%0d,%0d) got %0d want %0d", px, py, fb_addr, py * 80 + px);
            end
         end
         tick(); tick();
         tests_run++;
         if (color !== ref_pixel(px, py, s)) begin
            tests_failed++; $display("FAIL rand_color (%0d,%0d,s=%0b) got %h want %h", px, py, s, color, ref_pixel(px, py, s));
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp_q[$];
      swap_r_b = 1'($urandom_range(0, 1));
      for (int i = 0; i < 60; i++) begin
         int px, py;
         px = $urandom_range(0, 99);
         py = $urandom_range(0, 66);
         x = 7'(px); y = 7'(py);
         exp_q.push_back(ref_pixel(px, py, swap_r_b));
         tick();
         if (i >= 2) begin
            logic [15:0] e;
            e = exp_q.pop_front();
            tests_run++;
            if (color !== e) begin
               tests_failed++; $display("FAIL b2b_color idx %0d got %h want %h", i - 2, color, e);
            end
         end
      end
      swap_r_b = 1'b0;
   endtask

   task automatic test_fsm();
      rst = 1'b1; tick(); rst = 1'b0; tick(); tick();
      tests_run++;
      if (cap_hold !== 1'b0) begin
         tests_failed++; $display("FAIL wait_hold got %b want 0", cap_hold);
      end
      pixel(0, 0, 1'b0); tick(); tick();
      tests_run++;
      if (cap_hold !== 1'b0) begin
         tests_failed++; $display("FAIL no_arm_without_pulse got %b want 0", cap_hold);
      end
      pulse_cfd(); tick();
      tests_run++;
      if (cap_hold !== 1'b1) begin
         tests_failed++; $display("FAIL arm_hold got %b want 1", cap_hold);
      end
      scan_frame(100, 3000);
      tests_run++;
      if (frame_cnt !== 8'd1) begin
         tests_failed++; $display("FAIL frame_cnt1 got %0d want 1", frame_cnt);
      end
      tick();
      tests_run++;
      if (cap_hold !== 1'b0) begin
         tests_failed++; $display("FAIL hold_after_scan got %b want 0", cap_hold);
      end
      pixel(0, 0, 1'b0); tick(); tick();
      tests_run++;
      if (cap_hold !== 1'b0 || frame_cnt !== 8'd1) begin
         tests_failed++; $display("FAIL scan_pulses_ignored got hold=%b cnt=%0d want 0/1", cap_hold, frame_cnt);
      end
      pulse_cfd(); tick();
      scan_frame(6143, -1);
      tests_run++;
      if (frame_cnt !== 8'd2) begin
         tests_failed++; $display("FAIL frame_cnt2 got %0d want 2", frame_cnt);
      end
      tick(); pixel(0, 0, 1'b0); tick(); tick();
      tests_run++;
      if (cap_hold !== 1'b0) begin
         tests_failed++; $display("FAIL coincident_pulse_lost got %b want 0", cap_hold);
      end
      freeze = 1'b1; tick(); tick();
      tests_run++;
      if (cap_hold !== 1'b1) begin
         tests_failed++; $display("FAIL freeze_hold got %b want 1", cap_hold);
      end
      pixel(0, 0, 1'b0); freeze = 1'b0; tick(); tick();
      tests_run++;
      if (cap_hold !== 1'b0) begin
         tests_failed++; $display("FAIL freeze_no_transition got %b want 0", cap_hold);
      end
      pulse_cfd(); tick();
      for (int i = 0; i < 10; i++) pixel(i, 0, 1'b0);
      tests_run++;
      if (cap_hold !== 1'b1) begin
         tests_failed++; $display("FAIL mid_scan_hold got %b want 1", cap_hold);
      end
      rst = 1'b1; tick();
      tests_run++;
      if (cap_hold !== 1'b0 || frame_cnt !== 8'd0 || color !== 16'hF800) begin
         tests_failed++; $display("FAIL rst_mid_scan got hold=%b cnt=%0d color=%h want 0/0/F800", cap_hold, frame_cnt, color);
      end
      rst = 1'b0; tick(); tick();
      tests_run++;
      if (cap_hold !== 1'b0) begin
         tests_failed++; $display("FAIL post_rst_hold got %b want 0", cap_hold);
      end
   endtask

`ifdef OLED_FETCH_TESTPAT_EN
   task automatic test_testpat();
      int          xs [3] = '{0, 60, 95};
      logic [15:0] ws [3] = '{16'hFFFF, 16'hF800, 16'h0000};
      testpat = 1'b1; y = 7'd5;
      for (int i = 0; i < 3; i++) begin
         x = 7'(xs[i]);
         tick(); tick(); tick();
         tests_run++;
         if (color !== ws[i]) begin
            tests_failed++; $display("FAIL testpat x=%0d got %h want %h", xs[i], color, ws[i]);
         end
      end
      testpat = 1'b0;
   endtask
`endif

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      for (int a = 0; a < 8192; a++) mem[a] = 16'h0000;
      test_reset();
      test_corner();
      test_border();
      test_random();
      test_back_to_back();
`ifdef OLED_FETCH_TESTPAT_EN
      test_testpat();
`endif
      test_fsm();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

`default_nettype wire
